// File: rtl/cpu_microcode_pkg.sv
// Shared constants for the microcode decoder and the datapath.
// Holds the micro-state codes from the sequencer, the control-word bit
// indices, the decoder FSM state type and a bit-mask helper.
package cpu_microcode_pkg;

   localparam int CTRL_BITS = 19;

   localparam int CTRL_MAR_LOAD     = 0;
   localparam int CTRL_MAR_SRC_SP   = 1;
   localparam int CTRL_MEM_RD       = 2;
   localparam int CTRL_MEM_WR       = 3;
   localparam int CTRL_IR_LOAD      = 4;
   localparam int CTRL_PC_INC       = 5;
   localparam int CTRL_PC_LOAD      = 6;
   localparam int CTRL_PC_OE        = 7;
   localparam int CTRL_SP_INC       = 8;
   localparam int CTRL_SP_DEC       = 9;
   localparam int CTRL_REG_OE       = 10;
   localparam int CTRL_REG_WE       = 11;
   localparam int CTRL_TMP_LOAD     = 12;
   localparam int CTRL_TMP_OE       = 13;
   localparam int CTRL_ALU_EN       = 14;
   localparam int CTRL_FLAGS_LOAD   = 15;
   localparam int CTRL_IO_ADDR_LOAD = 16;
   localparam int CTRL_IO_RD        = 17;
   localparam int CTRL_IO_WR        = 18;

   localparam logic [7:0] STATE_FETCH_PC   = 8'h00;
   localparam logic [7:0] STATE_FETCH_INST = 8'h01;
   localparam logic [7:0] STATE_FETCH_SP   = 8'h02;
   localparam logic [7:0] STATE_INC_SP     = 8'h03;
   localparam logic [7:0] STATE_REG_STORE  = 8'h04;
   localparam logic [7:0] STATE_SET_REG    = 8'h05;
   localparam logic [7:0] STATE_MOV_FETCH  = 8'h06;
   localparam logic [7:0] STATE_MOV_LOAD   = 8'h07;
   localparam logic [7:0] STATE_MOV_STORE  = 8'h08;
   localparam logic [7:0] STATE_LDI        = 8'h09;
   localparam logic [7:0] STATE_JUMP       = 8'h0A;
   localparam logic [7:0] STATE_ALU_OP     = 8'h0B;
   localparam logic [7:0] STATE_SET_ADDR   = 8'h0C;
   localparam logic [7:0] STATE_OUT        = 8'h0D;
   localparam logic [7:0] STATE_IN         = 8'h0E;
   localparam logic [7:0] STATE_TMP_STORE  = 8'h0F;
   localparam logic [7:0] STATE_PC_STORE   = 8'h10;
   localparam logic [7:0] STATE_TMP_JUMP   = 8'h11;
   localparam logic [7:0] STATE_RET        = 8'h12;
   localparam logic [7:0] STATE_NEXT       = 8'h13;
   localparam logic [7:0] STATE_HALT       = 8'h14;

   typedef logic [CTRL_BITS-1:0] ctrl_t;

   typedef enum logic {
      MODE_RUN    = 1'b0,
      MODE_HALTED = 1'b1
   } mode_t;

   function automatic ctrl_t cbit(input int unsigned idx);
      return ctrl_t'(1) << idx;
   endfunction

endpackage

// File: rtl/cpu_microcode_if.sv
// Bus between the cycle sequencer (master) and the microcode decoder (slave).
//   state        sequencer -> decoder, micro-state code
//   ctrl         decoder control word to the datapath
//   reset_cycle  one-clock sequencer restart request
//   halted, err, err_state, instr_count  status
interface cpu_microcode_if #(
   parameter int CTRL_W = 19,
   parameter int CNT_W  = 16
);
   logic [7:0]        state;
   logic [CTRL_W-1:0] ctrl;
   logic              reset_cycle;
   logic              halted;
   logic              err;
   logic [7:0]        err_state;
   logic [CNT_W-1:0]  instr_count;

   modport master (
      output state,
      input  ctrl, reset_cycle, halted, err, err_state, instr_count
   );

   modport slave (
      input  state,
      output ctrl, reset_cycle, halted, err, err_state, instr_count
   );
endinterface

// File: rtl/cpu_microcode_rom.sv
// Combinational micro-state to control-word lookup.
//   state    in   micro-state code
//   ctrl     out  decoded control word (zero for NEXT, HALT and illegal codes)
//   illegal  out  code is not one of the STATE_* constants
import cpu_microcode_pkg::*;

module cpu_microcode_rom (
   input  logic [7:0] state,
   output ctrl_t      ctrl,
   output logic       illegal
);

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      case (state)
         STATE_FETCH_PC:   ctrl = cbit(CTRL_MAR_LOAD);
         STATE_FETCH_INST: ctrl = cbit(CTRL_MEM_RD) | cbit(CTRL_IR_LOAD) | cbit(CTRL_PC_INC);
         STATE_FETCH_SP:   ctrl = cbit(CTRL_MAR_LOAD) | cbit(CTRL_MAR_SRC_SP);
         STATE_INC_SP:     ctrl = cbit(CTRL_SP_INC);
         STATE_REG_STORE:  ctrl = cbit(CTRL_REG_OE) | cbit(CTRL_MEM_WR) | cbit(CTRL_SP_DEC);
         STATE_SET_REG:    ctrl = cbit(CTRL_MEM_RD) | cbit(CTRL_REG_WE);
         STATE_MOV_FETCH:  ctrl = cbit(CTRL_REG_OE) | cbit(CTRL_TMP_LOAD);
         STATE_MOV_LOAD:   ctrl = cbit(CTRL_TMP_OE);
         STATE_MOV_STORE:  ctrl = cbit(CTRL_TMP_OE) | cbit(CTRL_REG_WE);
         STATE_LDI:        ctrl = cbit(CTRL_MEM_RD) | cbit(CTRL_REG_WE) | cbit(CTRL_PC_INC);
         STATE_JUMP:       ctrl = cbit(CTRL_MEM_RD) | cbit(CTRL_PC_LOAD);
         STATE_ALU_OP:     ctrl = cbit(CTRL_ALU_EN) | cbit(CTRL_REG_WE) | cbit(CTRL_FLAGS_LOAD);
         STATE_SET_ADDR:   ctrl = cbit(CTRL_MEM_RD) | cbit(CTRL_IO_ADDR_LOAD) | cbit(CTRL_PC_INC);
         STATE_OUT:        ctrl = cbit(CTRL_REG_OE) | cbit(CTRL_IO_WR);
         STATE_IN:         ctrl = cbit(CTRL_IO_RD) | cbit(CTRL_REG_WE);
         STATE_TMP_STORE:  ctrl = cbit(CTRL_MEM_RD) | cbit(CTRL_TMP_LOAD) | cbit(CTRL_PC_INC);
         STATE_PC_STORE:   ctrl = cbit(CTRL_PC_OE) | cbit(CTRL_MEM_WR) | cbit(CTRL_SP_DEC);
         STATE_TMP_JUMP:   ctrl = cbit(CTRL_TMP_OE) | cbit(CTRL_PC_LOAD);
         STATE_RET:        ctrl = cbit(CTRL_MEM_RD) | cbit(CTRL_PC_LOAD);
         STATE_NEXT, STATE_HALT: ctrl = '0;
         default:          illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_microcode.sv
// Microcode decoder: registers the decoded control word, pulses reset_cycle
// back to the sequencer, latches HALT, captures the first illegal code and
// counts retired instructions (saturating).
//   clk    in  system clock
//   reset  in  asynchronous, active-high
//   bus    slave side of cpu_microcode_if
//
// mode        | meaning
// ------------+-----------------------------------------------------------
// MODE_RUN    | decode state each clock
// MODE_HALTED | HALT seen; outputs held quiet, status frozen until reset
import cpu_microcode_pkg::*;

module cpu_microcode #(
   parameter int CTRL_W = CTRL_BITS,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   cpu_microcode_if.slave    bus
);

   ctrl_t             rom_ctrl;
   logic              rom_illegal;
   mode_t             mode;
   logic [CTRL_W-1:0] ctrl;
   logic              reset_cycle;
   logic              halted;
   logic              err;
   logic [7:0]        err_state;
   logic [CNT_W-1:0]  instr_count;

   cpu_microcode_rom u_rom (
      .state   (bus.state),
      .ctrl    (rom_ctrl),
      .illegal (rom_illegal)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode        <= MODE_RUN;
         ctrl        <= '0;
         reset_cycle <= 1'b0;
         halted      <= 1'b0;
         err         <= 1'b0;
         err_state   <= 8'h00;
         instr_count <= '0;
      end else begin
         case (mode)
            MODE_RUN: begin
               ctrl        <= rom_ctrl;
               reset_cycle <= (bus.state == STATE_NEXT);
               if ((bus.state == STATE_FETCH_INST) && (instr_count != {CNT_W{1'b1}}))
                  instr_count <= instr_count + 1'b1;
               // Only the first illegal code is kept for post-mortem.
               if (rom_illegal && !err) begin
                  err       <= 1'b1;
                  err_state <= bus.state;
               end
               if (bus.state == STATE_HALT) begin
                  mode   <= MODE_HALTED;
                  halted <= 1'b1;
               end
            end
            default: begin
               ctrl        <= '0;
               reset_cycle <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ctrl        = ctrl;
   assign bus.reset_cycle = reset_cycle;
   assign bus.halted      = halted;
   assign bus.err         = err;
   assign bus.err_state   = err_state;
   assign bus.instr_count = instr_count;

endmodule
